waveshaper_curve_loader: RTL and testbench

Runtime-programmable soft-clip waveshaper. A byte-wide config stream loads a 256-entry signed transfer curve into a shadow bank. The new curve is committed to the audio path at a sample-safe boundary. The block sits in the overdrive chain where the fixed curve lookup would sit; it serves audio lookups with 1-cycle latency while a new curve is being written.

---
 rtl/waveshaper_pkg.sv | 16 +
 rtl/curve_ram.sv | 28 ++
 rtl/waveshaper_curve_loader.sv | 140 ++++++++++++++
 tb/tb_waveshaper_curve_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/waveshaper_pkg.sv
// Shared constants and state type for the programmable waveshaper curve loader.
package waveshaper_pkg;

   localparam int WS_WIDTH        = 24;
   localparam int WS_ADDR_W       = 8;
   localparam int BYTES_PER_ENTRY = WS_WIDTH / 8;
   localparam int DEPTH           = 2 ** WS_ADDR_W;
   localparam logic [WS_ADDR_W-1:0] ADDR_OFFSET = WS_ADDR_W'(2 ** (WS_ADDR_W - 1));

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/curve_ram.sv
// Two-bank curve storage: one synchronous write port, one registered read port.
// Address MSB selects the bank. Contents are not reset.
module curve_ram #(
   parameter int WIDTH = 24,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [2**AW];

   // Config-side write into the shadow bank.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Lookup read; holds its last value when no sample is issued.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/waveshaper_curve_loader.sv
// Runtime-programmable soft-clip waveshaper. A byte stream fills the shadow
// bank; the bank swap happens only in a cycle with no lookup in flight.
module waveshaper_curve_loader
   import waveshaper_pkg::*;
#(
   parameter int WIDTH  = WS_WIDTH,
   parameter int ADDR_W = WS_ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_start,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [7:0]              cfg_data,
   output logic                    load_busy,
   output logic                    load_done,
   output logic                    load_err,
   output logic                    curve_valid,
   output logic                    active_bank,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_signal,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] out_signal
);

   localparam int BPE    = WIDTH / 8;
   localparam int BCNT_W = (BPE > 1) ? $clog2(BPE) : 1;
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BPE - 1);
   localparam logic [ADDR_W-1:0] OFFSET    = ADDR_W'(2 ** (ADDR_W - 1));

   // Offset-binary index: top ADDR_W bits of the sample with the sign bias removed.
   function automatic logic [ADDR_W-1:0] lookup_idx(input logic signed [WIDTH-1:0] s);
      return s[WIDTH-1 -: ADDR_W] + OFFSET;
   endfunction

   state_t              state;
   logic [BCNT_W-1:0]   byte_cnt;
   logic [ADDR_W-1:0]   entry_cnt;
   logic [WIDTH-1:0]    asm_q;
   logic [WIDTH-1:0]    asm_next;
   logic                hs;
   logic                we;
   logic [WIDTH-1:0]    ram_q;
   logic signed [WIDTH-1:0] byp_p1;
   logic                sel_p1;
   logic                vld_p1;

   // A restart pulse takes priority over a coincident byte.
   assign hs        = (state == LOAD) && cfg_valid && !cfg_start;
   assign we        = hs && (byte_cnt == LAST_BYTE);
   assign asm_next  = (asm_q << 8) | WIDTH'(cfg_data);
   assign cfg_ready = (state == LOAD);
   assign load_busy = (state != IDLE);

   // Byte assembly register: MSB byte arrives first.
   always_ff @(posedge clk) begin
      if (hs) asm_q <= asm_next;
   end

   // Load/commit control.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         entry_cnt   <= '0;
         active_bank <= 1'b0;
         curve_valid <= 1'b0;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  state     <= LOAD;
                  byte_cnt  <= '0;
                  entry_cnt <= '0;
               end
            end
            LOAD: begin
               if (cfg_start) begin
                  load_err  <= 1'b1;
                  byte_cnt  <= '0;
                  entry_cnt <= '0;
               end else if (cfg_valid) begin
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt  <= '0;
                     entry_cnt <= entry_cnt + 1'b1;
                     if (&entry_cnt) state <= COMMIT;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            COMMIT: begin
               if (!in_valid) begin
                  active_bank <= ~active_bank;
                  curve_valid <= 1'b1;
                  load_done   <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   curve_ram #(
      .WIDTH (WIDTH),
      .AW    (ADDR_W + 1)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr ({~active_bank, entry_cnt}),
      .wdata (asm_next),
      .re    (in_valid),
      .raddr ({active_bank, lookup_idx(in_signal)}),
      .rdata (ram_q)
   );

   // Stage p1: bypass sample, curve/bypass select and valid, aligned with the RAM read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_p1 <= '0;
         sel_p1 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            byp_p1 <= in_signal;
            sel_p1 <= curve_valid;
         end
      end
   end

   assign out_valid  = vld_p1;
   assign out_signal = sel_p1 ? $signed(ram_q) : byp_p1;

endmodule

// File: tb/tb_waveshaper_curve_loader.sv
// Directed bench for waveshaper_curve_loader with a per-cycle reference model.
module tb_waveshaper_curve_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [7:0]  cfg_data = 8'h00;
   logic        load_busy, load_done, load_err, curve_valid, active_bank;
   logic        in_valid = 1'b0;
   logic [23:0] in_signal = 24'h0;
   logic        out_valid;
   logic [23:0] out_signal;

   int npass = 0;
   int ntot  = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   waveshaper_curve_loader #(.WIDTH(24), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
      .curve_valid(curve_valid), .active_bank(active_bank),
      .in_valid(in_valid), .in_signal(in_signal),
      .out_valid(out_valid), .out_signal(out_signal)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: two curve tables, active-bank pointer, byte counting.
   logic [23:0] mbank [2][256];
   logic [23:0] masm, esig;
   logic [7:0]  mix;
   bit mact, mcv, mload, mpend, edone, eerr, evld;
   int mbytes;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mact = 0; mcv = 0; mload = 0; mpend = 0;
         edone = 0; eerr = 0; evld = 0; esig = '0; mbytes = 0;
      end else begin
         edone = 0; eerr = 0;
         evld  = in_valid;
         if (in_valid) begin
            mix  = in_signal[23:16] + 8'd128;
            esig = mcv ? mbank[mact][mix] : in_signal;
         end
         if (mload) begin
            if (cfg_start) begin
               eerr = 1; mbytes = 0;
            end else if (cfg_valid) begin
               masm = {masm[15:0], cfg_data};
               mbytes++;
               if (mbytes % 3 == 0) mbank[!mact][mbytes/3 - 1] = masm;
               if (mbytes == 768) begin mload = 0; mpend = 1; end
            end
         end else if (mpend) begin
            if (!in_valid) begin mact = !mact; mcv = 1; edone = 1; mpend = 0; end
         end else if (cfg_start) begin
            mload = 1; mbytes = 0;
         end
      end
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_cfg_ready",   cfg_ready,   mload);
         chk("m_load_busy",   load_busy,   mload | mpend);
         chk("m_load_done",   load_done,   edone);
         chk("m_load_err",    load_err,    eerr);
         chk("m_curve_valid", curve_valid, mcv);
         chk("m_active_bank", active_bank, mact);
         chk("m_out_valid",   out_valid,   evld);
         chk("m_out_signal",  out_signal,  esig);
      end
   end

   function automatic logic [7:0] byte_of(input int pat, input int i);
      logic [7:0]  k;
      logic [23:0] v;
      k = 8'(i / 3);
      case (pat)
         0:       v = {k, 16'h0000};
         1:       v = 24'h0;
         default: v = {~k, 8'h11, 8'h22};
      endcase
      return 8'(v >> (8 * (2 - i % 3)));
   endfunction

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic load(input int pat, input int first, input int last, input bit start, input bit gaps);
      if (start) begin
         cfg_start = 1'b1;
         @(posedge clk); #1;
         cfg_start = 1'b0;
      end
      for (int i = first; i < last; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
               cfg_valid = 1'b0;
               cfg_data  = 8'($urandom);
               @(posedge clk); #1;
            end
         end
         cfg_valid = 1'b1;
         cfg_data  = byte_of(pat, i);
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
   endtask

   task automatic lookup(input logic [23:0] s, output logic [23:0] r);
      in_valid  = 1'b1;
      in_signal = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      r = out_signal;
   endtask

   task automatic wait_commit(input logic exp_bank);
      @(posedge clk); #1;
      chk("commit_done", load_done, 1'b1);
      chk("commit_bank", active_bank, exp_bank);
      chk("commit_cv", curve_valid, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] r;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      chk("rst_cfg_ready", cfg_ready, 1'b0);
      chk("rst_busy", load_busy, 1'b0);
      chk("rst_out_signal", out_signal, 24'h0);

      // Bypass before any curve exists.
      lookup(24'h123456, r);
      chk("bypass_out", r, 24'h123456);
      chk("bypass_vld", out_valid, 1'b1);
      chk("bypass_cv", curve_valid, 1'b0);

      // Full back-to-back load of entry k = {k,00,00}.
      load(0, 0, 768, 1'b1, 1'b0);
      wait_commit(1'b1);
      lookup(24'h000000, r); chk("t2_zero", r, 24'h800000);
      lookup(24'h800000, r); chk("t2_negfs", r, 24'h000000);
      lookup(24'h7FFFFF, r); chk("t2_posfs", r, 24'hFF0000);

      // Same curve with random handshake gaps and junk on idle bytes.
      load(0, 0, 768, 1'b1, 1'b1);
      wait_commit(1'b0);
      lookup(24'h000000, r); chk("t3_zero", r, 24'h800000);
      lookup(24'h800000, r); chk("t3_negfs", r, 24'h000000);
      lookup(24'h7FFFFF, r); chk("t3_posfs", r, 24'hFF0000);
      chk("t3_ready_idle", cfg_ready, 1'b0);

      // Abort a zero-curve load after 100 bytes; restart collides with a byte.
      load(1, 0, 100, 1'b1, 1'b0);
      cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hAA;
      @(posedge clk); #1;
      cfg_start = 1'b0; cfg_valid = 1'b0;
      chk("t4_err", load_err, 1'b1);
      chk("t4_busy", load_busy, 1'b1);
      lookup(24'h000000, r); chk("t4_old_curve", r, 24'h800000);
      chk("t4_bank", active_bank, 1'b0);

      // Continue the restarted load; hold lookups across the final byte.
      load(2, 0, 767, 1'b0, 1'b0);
      cfg_valid = 1'b1; cfg_data = byte_of(2, 767);
      in_valid = 1'b1; in_signal = 24'h000000;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      chk("t5_old0", out_signal, 24'h800000);
      chk("t5_bank0", active_bank, 1'b0);
      for (int j = 1; j < 5; j++) begin
         @(posedge clk); #1;
         chk("t5_old", out_signal, 24'h800000);
         chk("t5_bank_hold", active_bank, 1'b0);
         chk("t5_no_done", load_done, 1'b0);
      end
      in_valid = 1'b0;
      wait_commit(1'b1);
      lookup(24'h000000, r); chk("t5_new", r, 24'h7F1122);
      lookup(24'h7FFFFF, r); chk("t5_new_top", r, 24'h001122);

      // Reset in the middle of a load.
      load(0, 0, 300, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t6_cv", curve_valid, 1'b0);
      chk("t6_bank", active_bank, 1'b0);
      chk("t6_busy", load_busy, 1'b0);
      chk("t6_ready", cfg_ready, 1'b0);
      chk("t6_out", out_signal, 24'h0);
      chk("t6_vld", out_valid, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lookup(24'hABCDEF, r); chk("t6_bypass", r, 24'hABCDEF);
      load(0, 0, 768, 1'b1, 1'b0);
      wait_commit(1'b1);
      lookup(24'h000000, r); chk("t6_reload", r, 24'h800000);
      lookup(24'hC00000, r); chk("t6_reload_neg", r, 24'h400000);

      repeat (2) @(posedge clk);
      #1 chk_en = 1'b0;
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
